vga_bounce_box: RTL and testbench
=================================

# vga_bounce_box

Pixel-source stage that sits directly upstream of the VGA timing/output block. It takes the timing block's pixel counters and pixel strobe, and returns one registered RGB332 byte per pixel: a solid square on a flat background. The square moves diagonally by a fixed step once per frame and bounces off the edges of the 640x480 active area. Position updates happen only during vertical blanking, so a frame is never torn.

## Interface
Parameters:
- H_ACT_BEGIN, 143, first active hcount
- H_ACT_END, 783, first hcount past active (640 px)
- V_ACT_BEGIN, 34, first active vcount
- V_ACT_END, 514, first vcount past active (480 lines)
- BOX_SIZE, 32, square edge in pixels; must be less than 480
- STEP, 2, pixels moved per frame on each axis; 1..BOX_SIZE
- BOX_COLOR, 8'b11100000, RGB332 colour of the square
- BG_COLOR, 8'b00000011, RGB332 colour of active pixels outside the square

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1, system clock
- rst, in, 1, synchronous active-high reset, sampled on the rising edge of clk
- pix_en, in, 1, one-cycle pixel strobe, one per pixel (clk/2 in the current design)
- hcount, in, 10, horizontal pixel counter from the timing block
- vcount, in, 10, vertical line counter from the timing block
- freeze, in, 1, when high the square does not move; the frame counter still advances
- pix_data, out, 8, registered RGB332 pixel, MSB = red2
- pix_act, out, 1, registered active-area flag aligned with pix_data
- frame_cnt, out, 16, count of update points seen since reset; wraps

## Operation
State:
- x_pos: 10 bits, range 0..X_MAX, where X_MAX = 640 − BOX_SIZE.
- y_pos: 10 bits, range 0..Y_MAX, where Y_MAX = 480 − BOX_SIZE.
- dir_x: 1 bit, 1 = right.
- dir_y: 1 bit, 1 = down.

Position is relative to the top-left corner of the active area.

Active area: act = (H_ACT_BEGIN ≤ hcount < H_ACT_END) && (V_ACT_BEGIN ≤ vcount < V_ACT_END).

In-box test:
- in_box = (H_ACT_BEGIN+x_pos ≤ hcount < H_ACT_BEGIN+x_pos+BOX_SIZE) && (V_ACT_BEGIN+y_pos ≤ vcount < V_ACT_BEGIN+y_pos+BOX_SIZE).
- All comparisons are unsigned at 11-bit width, so the sums do not overflow.

Pixel output, on each pix_en:
- pix_act <= act.
- pix_data <= act ? (in_box ? BOX_COLOR : BG_COLOR) : 8'h00.

Update point: pix_en && hcount==0 && vcount==V_ACT_END. This occurs exactly once per frame, in vertical blanking. At the update point:
- frame_cnt increments; 16'hFFFF wraps to 0.
- If freeze is low, x moves:
  - dir_x=1 and x_pos+STEP ≥ X_MAX → x_pos=X_MAX, dir_x=0.
  - dir_x=1 otherwise → x_pos += STEP.
  - dir_x=0 and x_pos ≤ STEP → x_pos=0, dir_x=1.
  - dir_x=0 otherwise → x_pos −= STEP.
- If freeze is low, y moves by the same rules using Y_MAX and dir_y.
- If freeze is high, x_pos, y_pos, dir_x and dir_y hold.

Between update points, x_pos, y_pos, dir_x and dir_y never change.

Reset values: x_pos=0, y_pos=0, dir_x=1, dir_y=1, pix_data=8'h00, pix_act=0, frame_cnt=0.

Reset mid-frame: all state returns to reset values on the next clk edge. The next update point moves the square from (0,0) to (STEP,STEP).

## Timing
- Latency: pix_data and pix_act change on the clk edge where pix_en is high. They reflect the hcount/vcount sampled on that edge. Between strobes they hold.
- The consumer delays hsync/vsync by one pixel strobe to stay aligned with pix_data.
- pix_en low: no state changes, except that rst still applies.
- rst and pix_en high in the same cycle: rst wins; no pixel and no update occurs.
- freeze is sampled only at the update point.
- An update point with the corner reached on both axes reverses both directions in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset with a pixel at hcount=143, vcount=34 → next pix_data=BOX_COLOR (8'hE0), pix_act=1. hcount=175 → BG_COLOR (8'h03). hcount=100 → 8'h00, pix_act=0.
- Run one frame through the update point (hcount=0, vcount=514) → frame_cnt=1. The square's top-left corner is now at hcount=145, vcount=36: hcount=144 gives 8'h03, hcount=145 gives 8'hE0 on line 36.
- Preload by running 304 frames → x_pos=608=X_MAX with dir_x flipped to left. Next frame → x_pos=606. Pixel at hcount=783 → 8'h00 (no overdraw into blanking).
- Hold freeze=1 across 3 update points → frame_cnt advances by 3 and the square position is unchanged.
- Assert rst mid-line at hcount=400, vcount=200 → the next clk gives pix_data=0, pix_act=0, frame_cnt=0. After the next update point the position is (2,2).
- Hold pix_en=0 for 10 clks around the update point → no state change. Pulse pix_en with hcount=0, vcount=514 → exactly one update.

Source files
------------

// File: rtl/vga_bounce_box_if.sv
// Pixel-source bus between the VGA timing block and the bouncing-box generator.
//   master : timing side. Drives pix_en/hcount/vcount/freeze and receives the pixel.
//   slave  : pixel source. Receives the counters and drives pix_data/pix_act/frame_cnt.
// Signals:
//   pix_en    - one-cycle pixel strobe
//   hcount    - horizontal pixel counter
//   vcount    - vertical line counter
//   freeze    - hold the square in place at the next update point
//   pix_data  - registered RGB332 pixel, MSB = red2
//   pix_act   - registered active-area flag, aligned with pix_data
//   frame_cnt - update points seen since reset; wraps at 16 bits
interface vga_bounce_box_if;
  logic        pix_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        freeze;
  logic [7:0]  pix_data;
  logic        pix_act;
  logic [15:0] frame_cnt;

  modport master (
    output pix_en, hcount, vcount, freeze,
    input  pix_data, pix_act, frame_cnt
  );

  modport slave (
    input  pix_en, hcount, vcount, freeze,
    output pix_data, pix_act, frame_cnt
  );
endinterface

// File: rtl/vga_bounce_box.sv
// Pixel source for a 640x480 VGA timing block: draws a solid square on a flat
// background and bounces it diagonally off the edges of the active area. The
// square moves once per frame, at the update point in vertical blanking
// (hcount==0, vcount==V_ACT_END), so a displayed frame is never torn.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - vga_bounce_box_if.slave: counters/strobe/freeze in, pixel/flags out
// All outputs are registered and update only on pix_en (or rst).
module vga_bounce_box #(
  parameter int unsigned H_ACT_BEGIN = 143,
  parameter int unsigned H_ACT_END   = 783,
  parameter int unsigned V_ACT_BEGIN = 34,
  parameter int unsigned V_ACT_END   = 514,
  parameter int unsigned BOX_SIZE    = 32,
  parameter int unsigned STEP        = 2,
  parameter logic [7:0]  BOX_COLOR   = 8'b11100000,
  parameter logic [7:0]  BG_COLOR    = 8'b00000011
) (
  input  logic            clk,
  input  logic            rst,
  vga_bounce_box_if.slave bus
);

  localparam logic [9:0]  X_MAX  = 10'(640 - BOX_SIZE);
  localparam logic [9:0]  Y_MAX  = 10'(480 - BOX_SIZE);
  localparam logic [10:0] H_BEG  = 11'(H_ACT_BEGIN);
  localparam logic [10:0] H_END  = 11'(H_ACT_END);
  localparam logic [10:0] V_BEG  = 11'(V_ACT_BEGIN);
  localparam logic [10:0] V_END  = 11'(V_ACT_END);
  localparam logic [10:0] BOX_11 = 11'(BOX_SIZE);

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;  // 1 = increasing (right / down)
  } axis_t;

  // One bounce step along an axis. Hitting an edge clamps to it and reverses,
  // so the square always lands exactly on 0 or lim before turning around.
  function automatic axis_t move_axis(input logic [9:0] pos, input logic dir,
                                      input logic [9:0] lim);
    axis_t       r;
    logic [10:0] p;
    logic [10:0] s;
    logic [10:0] m;
    p     = {1'b0, pos};
    s     = 11'(STEP);
    m     = {1'b0, lim};
    r.pos = pos;
    r.dir = dir;
    if (dir) begin
      if (p + s >= m) begin
        r.pos = lim;
        r.dir = 1'b0;
      end else begin
        r.pos = 10'(p + s);
      end
    end else begin
      if (p <= s) begin
        r.pos = '0;
        r.dir = 1'b1;
      end else begin
        r.pos = 10'(p - s);
      end
    end
    return r;
  endfunction

  // Square state
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic        dir_x;
  logic        dir_y;

  // Output registers
  logic [7:0]  pix_data_q;
  logic        pix_act_q;
  logic [15:0] frame_cnt_q;

  // Combinational next values
  logic [10:0] h11;
  logic [10:0] v11;
  logic        act;
  logic        in_box;
  logic        update_pt;
  logic [7:0]  pix_next;
  axis_t       x_nxt;
  axis_t       y_nxt;

  // 11-bit compares so BEGIN + pos + BOX_SIZE never wraps.
  assign h11 = {1'b0, bus.hcount};
  assign v11 = {1'b0, bus.vcount};

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    act       = 1'b0;
    in_box    = 1'b0;
    update_pt = 1'b0;
    pix_next  = 8'h00;
    x_nxt     = move_axis(x_pos, dir_x, X_MAX);
    y_nxt     = move_axis(y_pos, dir_y, Y_MAX);

    act    = (h11 >= H_BEG) && (h11 < H_END) &&
             (v11 >= V_BEG) && (v11 < V_END);
    in_box = (h11 >= H_BEG + {1'b0, x_pos}) &&
             (h11 <  H_BEG + {1'b0, x_pos} + BOX_11) &&
             (v11 >= V_BEG + {1'b0, y_pos}) &&
             (v11 <  V_BEG + {1'b0, y_pos} + BOX_11);

    if (act) begin
      pix_next = in_box ? BOX_COLOR : BG_COLOR;
    end

    // First pixel of the first blanking line: once per frame, never visible.
    update_pt = (bus.hcount == 10'd0) && (v11 == V_END);
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_pos       <= '0;
      y_pos       <= '0;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      pix_data_q  <= 8'h00;
      pix_act_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else if (bus.pix_en) begin
      pix_act_q  <= act;
      pix_data_q <= pix_next;
      if (update_pt) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        if (!bus.freeze) begin
          x_pos <= x_nxt.pos;
          dir_x <= x_nxt.dir;
          y_pos <= y_nxt.pos;
          dir_y <= y_nxt.dir;
        end
      end
    end
  end

  assign bus.pix_data  = pix_data_q;
  assign bus.pix_act   = pix_act_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Self-checking bench for vga_bounce_box. A behavioural model holds the square
// as plain integers and applies the bounce rules per update point; every
// registered output is compared against it, plus directed literal values.
module tb_vga_bounce_box;

  localparam int H_B  = 143;
  localparam int H_E  = 783;
  localparam int V_B  = 34;
  localparam int V_E  = 514;
  localparam int BOX  = 32;
  localparam int STEP = 2;
  localparam int XMAX = 640 - BOX;
  localparam int YMAX = 480 - BOX;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_bounce_box_if bus ();

  vga_bounce_box dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int mx, my, mfc;
  bit mdx, mdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mdx = 1'b1; mdy = 1'b1; mfc = 0;
  endtask

  task automatic model_axis(inout int p, inout bit d, input int lim);
    if (d) begin
      if (p + STEP >= lim) begin p = lim; d = 1'b0; end
      else p = p + STEP;
    end else begin
      if (p <= STEP) begin p = 0; d = 1'b1; end
      else p = p - STEP;
    end
  endtask

  task automatic model_update(input bit frz);
    mfc = (mfc + 1) % 65536;
    if (!frz) begin
      model_axis(mx, mdx, XMAX);
      model_axis(my, mdy, YMAX);
    end
  endtask

  // Returns {act, colour} for a pixel given the current model position.
  function automatic logic [8:0] model_pixel(input int h, input int v);
    bit act, inb;
    act = (h >= H_B) && (h < H_E) && (v >= V_B) && (v < V_E);
    inb = (h >= H_B + mx) && (h < H_B + mx + BOX) &&
          (v >= V_B + my) && (v < V_B + my + BOX);
    if (!act) return 9'h000;
    return inb ? {1'b1, 8'hE0} : {1'b1, 8'h03};
  endfunction

  // One strobed pixel, checked right after the edge and again one clk later
  // (outputs must hold between strobes).
  task automatic do_pix(input int h, input int v, input bit frz);
    logic [8:0] exp;
    exp        = model_pixel(h, v);
    bus.hcount = 10'(h);
    bus.vcount = 10'(v);
    bus.freeze = frz;
    bus.pix_en = 1'b1;
    @(posedge clk);
    #1;
    bus.pix_en = 1'b0;
    if (h == 0 && v == V_E) model_update(frz);
    check("pix_data", 32'(bus.pix_data), 32'(exp[7:0]));
    check("pix_act", 32'(bus.pix_act), 32'(exp[8]));
    check("frame_cnt", 32'(bus.frame_cnt), 32'(mfc));
    @(posedge clk);
    #1;
    check("hold_data", 32'(bus.pix_data), 32'(exp[7:0]));
    check("hold_act", 32'(bus.pix_act), 32'(exp[8]));
  endtask

  task automatic do_update(input bit frz);
    do_pix(0, V_E, frz);
  endtask

  // Probe the box corners and their outside neighbours at the model position.
  task automatic probe_pos();
    do_pix(H_B + mx,           V_B + my,           1'b0);
    do_pix(H_B + mx - 1,       V_B + my,           1'b0);
    do_pix(H_B + mx,           V_B + my - 1,       1'b0);
    do_pix(H_B + mx + BOX - 1, V_B + my + BOX - 1, 1'b0);
    do_pix(H_B + mx + BOX,     V_B + my + BOX - 1, 1'b0);
    do_pix(H_B + mx + BOX - 1, V_B + my + BOX,     1'b0);
  endtask

  // Reset pulse coinciding with a strobe at (h, v): rst must win.
  task automatic reset_with_pix(input int h, input int v);
    bus.hcount = 10'(h);
    bus.vcount = 10'(v);
    bus.pix_en = 1'b1;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.pix_en = 1'b0;
    model_reset();
    check("rst_data", 32'(bus.pix_data), 32'h00);
    check("rst_act", 32'(bus.pix_act), 32'h0);
    check("rst_frame", 32'(bus.frame_cnt), 32'h0);
  endtask

  initial begin
    int fc0;
    bus.pix_en = 1'b0;
    bus.hcount = '0;
    bus.vcount = '0;
    bus.freeze = 1'b0;
    rst        = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", 32'(bus.pix_data), 32'h00);
    check("reset_act", 32'(bus.pix_act), 32'h0);
    check("reset_frame", 32'(bus.frame_cnt), 32'h0);
    rst = 1'b0;

    // Pixels at reset position
    do_pix(143, 34, 1'b0);
    check("tp_box_corner", 32'(bus.pix_data), 32'hE0);
    check("tp_box_act", 32'(bus.pix_act), 32'h1);
    do_pix(175, 34, 1'b0);
    check("tp_bg_right", 32'(bus.pix_data), 32'h03);
    do_pix(100, 34, 1'b0);
    check("tp_blank", 32'(bus.pix_data), 32'h00);
    check("tp_blank_act", 32'(bus.pix_act), 32'h0);

    // First update
    do_update(1'b0);
    check("tp_frame1", 32'(bus.frame_cnt), 32'd1);
    do_pix(144, 36, 1'b0);
    check("tp_left_of_box", 32'(bus.pix_data), 32'h03);
    do_pix(145, 36, 1'b0);
    check("tp_new_corner", 32'(bus.pix_data), 32'hE0);

    // Right-edge bounce: after 304 frames x sits at 608
    repeat (303) do_update(1'b0);
    check("tp_frame304", 32'(bus.frame_cnt), 32'd304);
    do_pix(H_B + 608, V_B + my, 1'b0);
    check("tp_xmax_in", 32'(bus.pix_data), 32'hE0);
    do_pix(H_B + 607, V_B + my, 1'b0);
    check("tp_xmax_left", 32'(bus.pix_data), 32'h03);
    do_pix(783, V_B + my, 1'b0);
    check("tp_no_overdraw", 32'(bus.pix_data), 32'h00);
    do_update(1'b0);
    do_pix(H_B + 606, V_B + my, 1'b0);
    check("tp_x606_in", 32'(bus.pix_data), 32'hE0);
    do_pix(H_B + 606 + BOX, V_B + my, 1'b0);
    check("tp_x606_right", 32'(bus.pix_data), 32'h03);
    probe_pos();

    // Freeze across 3 update points
    fc0 = mfc;
    repeat (3) do_update(1'b1);
    check("tp_freeze_frames", 32'(bus.frame_cnt), 32'(fc0 + 3));
    probe_pos();

    // Reset mid-line, then reset coinciding with an update strobe
    reset_with_pix(400, 200);
    reset_with_pix(0, V_E);
    do_update(1'b0);
    do_pix(145, 36, 1'b0);
    check("tp_rst_pos_in", 32'(bus.pix_data), 32'hE0);
    do_pix(144, 36, 1'b0);
    check("tp_rst_pos_left", 32'(bus.pix_data), 32'h03);
    do_pix(145, 35, 1'b0);
    check("tp_rst_pos_above", 32'(bus.pix_data), 32'h03);

    // pix_en low around the update point: nothing may change
    bus.hcount = 10'd0;
    bus.vcount = 10'(V_E);
    bus.freeze = 1'b0;
    bus.pix_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("tp_noen_frame", 32'(bus.frame_cnt), 32'(mfc));
    probe_pos();
    do_update(1'b0);
    check("tp_single_update", 32'(bus.frame_cnt), 32'(mfc));
    probe_pos();

    // Randomized traffic: mixed pixels, updates, freezes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 12) begin
        do_update($urandom_range(0, 3) == 0);
      end else if (r == 12) begin
        reset_with_pix(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
      end else if (r < 60) begin
        do_pix(H_B + mx + int'($urandom_range(0, BOX + 1)) - 1,
               V_B + my + int'($urandom_range(0, BOX + 1)) - 1, 1'b0);
      end else begin
        do_pix(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 1'b0);
      end
    end
    probe_pos();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
